// File: rtl/rs_station_bank_pkg.sv
// Shared types and constants for the reservation-station bank.
// Tags are entry index + 1 so that tag 0 can mean "operand already valid".
package data_types;

  localparam int NUM_RS     = 6;
  localparam int NUM_ALU_RS = 3;
  localparam int XLEN       = 32;
  localparam int ADDR_W     = $clog2(NUM_RS);
  localparam int TAG_W      = $clog2(NUM_RS + 1);

  typedef enum logic {FG_ALU, FG_SHIFT} functional_group_t;

  typedef logic [TAG_W-1:0] rs_tag_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    RS_FREE   = 2'd0,
    RS_WAIT   = 2'd1,
    RS_READY  = 2'd2,
    RS_ISSUED = 2'd3
  } rs_state_t;

  function automatic functional_group_t group_of(input int idx);
    return (idx < NUM_ALU_RS) ? FG_ALU : FG_SHIFT;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: FREE/WAIT/READY/ISSUED FSM with CDB operand
// capture, allocation-time CDB bypass and self-free on its own result tag.
module rs_entry import data_types::*; #(
  parameter rs_tag_t MY_TAG = rs_tag_t'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic             issue_i,
  input  opcode_t          alloc_op_i,
  input  rs_tag_t          src1_tag_i,
  input  rs_tag_t          src2_tag_i,
  input  logic [XLEN-1:0]  src1_value_i,
  input  logic [XLEN-1:0]  src2_value_i,
  input  logic             cdb_valid_i,
  input  rs_tag_t          cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  output rs_state_t        state_o,
  output opcode_t          op_o,
  output logic [XLEN-1:0]  src1_o,
  output logic [XLEN-1:0]  src2_o
);

  rs_state_t       state_r;
  opcode_t         op_r;
  rs_tag_t         tag1_r, tag2_r;
  logic [XLEN-1:0] val1_r, val2_r;

  logic            cdb_ok;
  rs_tag_t         a1_tag, a2_tag, w1_tag, w2_tag;
  logic [XLEN-1:0] a1_val, a2_val, w1_val, w2_val;

  // Resolve operands against the CDB, both for a new allocation and for a waiting entry
  always_comb begin
    cdb_ok = cdb_valid_i && (cdb_tag_i != '0);
    a1_tag = (cdb_ok && (src1_tag_i == cdb_tag_i)) ? '0 : src1_tag_i;
    a1_val = (cdb_ok && (src1_tag_i == cdb_tag_i)) ? cdb_value_i : src1_value_i;
    a2_tag = (cdb_ok && (src2_tag_i == cdb_tag_i)) ? '0 : src2_tag_i;
    a2_val = (cdb_ok && (src2_tag_i == cdb_tag_i)) ? cdb_value_i : src2_value_i;
    w1_tag = (cdb_ok && (tag1_r == cdb_tag_i)) ? '0 : tag1_r;
    w1_val = (cdb_ok && (tag1_r == cdb_tag_i)) ? cdb_value_i : val1_r;
    w2_tag = (cdb_ok && (tag2_r == cdb_tag_i)) ? '0 : tag2_r;
    w2_val = (cdb_ok && (tag2_r == cdb_tag_i)) ? cdb_value_i : val2_r;
  end

  // Entry FSM and operand storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= RS_FREE;
      op_r    <= OP_ADD;
      tag1_r  <= '0;
      tag2_r  <= '0;
      val1_r  <= '0;
      val2_r  <= '0;
    end else begin
      case (state_r)
        RS_FREE: begin
          if (alloc_i) begin
            op_r    <= alloc_op_i;
            tag1_r  <= a1_tag;
            tag2_r  <= a2_tag;
            val1_r  <= a1_val;
            val2_r  <= a2_val;
            state_r <= ((a1_tag == '0) && (a2_tag == '0)) ? RS_READY : RS_WAIT;
          end
        end
        RS_WAIT: begin
          tag1_r <= w1_tag;
          tag2_r <= w2_tag;
          val1_r <= w1_val;
          val2_r <= w2_val;
          if ((w1_tag == '0) && (w2_tag == '0)) state_r <= RS_READY;
        end
        RS_READY: begin
          if (issue_i) state_r <= RS_ISSUED;
        end
        RS_ISSUED: begin
          if (cdb_ok && (cdb_tag_i == MY_TAG)) state_r <= RS_FREE;
        end
        default: state_r <= RS_FREE;
      endcase
    end
  end

  assign state_o = state_r;
  assign op_o    = op_r;
  assign src1_o  = val1_r;
  assign src2_o  = val2_r;

endmodule

// File: rtl/rs_station_bank_chk.sv
// Simulation-only checker: flags allocations that the bank silently drops
// (target slot busy or index beyond the last entry).
module rs_station_bank_chk import data_types::*; (
  input logic              clk_i,
  input logic              rst_i,
  input logic              alloc_valid_i,
  input logic [ADDR_W-1:0] alloc_addr_i,
  input logic [NUM_RS-1:0] busy_bus_i
);

  logic alloc_legal;

  always_comb begin
    alloc_legal = (alloc_addr_i < ADDR_W'(NUM_RS)) && !busy_bus_i[alloc_addr_i];
  end

  // Allocation must target an existing FREE slot
  always @(posedge clk_i) begin
    if (!rst_i && alloc_valid_i) begin
      assert (alloc_legal)
        else $warning("rs_station_bank: allocation to slot %0d dropped (busy or out of range)", alloc_addr_i);
    end
  end

endmodule

// File: rtl/rs_station_bank.sv
// Reservation-station bank: NUM_RS entries, split into ALU and SHIFT groups,
// each with a lowest-index issue selector and a lock that holds the choice until handshake.
module rs_station_bank import data_types::*; (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  opcode_t           alloc_op_i,
  input  rs_tag_t           src1_tag_i,
  input  rs_tag_t           src2_tag_i,
  input  logic [XLEN-1:0]   src1_value_i,
  input  logic [XLEN-1:0]   src2_value_i,
  input  logic              cdb_valid_i,
  input  rs_tag_t           cdb_tag_i,
  input  logic [XLEN-1:0]   cdb_value_i,
  output logic [NUM_RS-1:0] busy_bus_o,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output opcode_t           alu_op_o,
  output logic [XLEN-1:0]   alu_src1_o,
  output logic [XLEN-1:0]   alu_src2_o,
  output rs_tag_t           alu_tag_o,
  output logic              shift_valid_o,
  input  logic              shift_ready_i,
  output opcode_t           shift_op_o,
  output logic [XLEN-1:0]   shift_src1_o,
  output logic [XLEN-1:0]   shift_src2_o,
  output rs_tag_t           shift_tag_o
);

  rs_state_t       ent_state [NUM_RS];
  opcode_t         ent_op    [NUM_RS];
  logic [XLEN-1:0] ent_src1  [NUM_RS];
  logic [XLEN-1:0] ent_src2  [NUM_RS];

  logic [NUM_RS-1:0] alloc_vec, issue_vec, alu_rdy, shift_rdy;

  logic              alu_lock_v, shift_lock_v;
  logic [ADDR_W-1:0] alu_lock_idx, shift_lock_idx;
  logic [ADDR_W-1:0] alu_pick, shift_pick, alu_idx, shift_idx;
  logic              alu_any, shift_any, alu_fire, shift_fire;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_ent
    assign alloc_vec[i]  = alloc_valid_i && (alloc_addr_i == ADDR_W'(i));
    assign busy_bus_o[i] = (ent_state[i] != RS_FREE);
    assign alu_rdy[i]    = (ent_state[i] == RS_READY) && (group_of(i) == FG_ALU);
    assign shift_rdy[i]  = (ent_state[i] == RS_READY) && (group_of(i) == FG_SHIFT);

    rs_entry #(.MY_TAG(rs_tag_t'(i + 1))) u_entry (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .alloc_i      (alloc_vec[i]),
      .issue_i      (issue_vec[i]),
      .alloc_op_i   (alloc_op_i),
      .src1_tag_i   (src1_tag_i),
      .src2_tag_i   (src2_tag_i),
      .src1_value_i (src1_value_i),
      .src2_value_i (src2_value_i),
      .cdb_valid_i  (cdb_valid_i),
      .cdb_tag_i    (cdb_tag_i),
      .cdb_value_i  (cdb_value_i),
      .state_o      (ent_state[i]),
      .op_o         (ent_op[i]),
      .src1_o       (ent_src1[i]),
      .src2_o       (ent_src2[i])
    );
  end

  // Lowest-index READY entry per group; a held lock overrides the fresh pick
  always_comb begin
    alu_pick   = '0;
    alu_any    = 1'b0;
    shift_pick = '0;
    shift_any  = 1'b0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      alu_pick   = alu_rdy[i]   ? ADDR_W'(i) : alu_pick;
      shift_pick = shift_rdy[i] ? ADDR_W'(i) : shift_pick;
      alu_any    = alu_any   | alu_rdy[i];
      shift_any  = shift_any | shift_rdy[i];
    end
    alu_idx       = alu_lock_v   ? alu_lock_idx   : alu_pick;
    shift_idx     = shift_lock_v ? shift_lock_idx : shift_pick;
    alu_valid_o   = alu_lock_v   | alu_any;
    shift_valid_o = shift_lock_v | shift_any;
    alu_fire      = alu_valid_o   && alu_ready_i;
    shift_fire    = shift_valid_o && shift_ready_i;
  end

  // Issue payload muxes and per-entry handshake strobes
  always_comb begin
    alu_op_o     = alu_valid_o ? ent_op[alu_idx]   : OP_ADD;
    alu_src1_o   = alu_valid_o ? ent_src1[alu_idx] : '0;
    alu_src2_o   = alu_valid_o ? ent_src2[alu_idx] : '0;
    alu_tag_o    = alu_valid_o ? rs_tag_t'(alu_idx) + rs_tag_t'(1) : '0;
    shift_op_o   = shift_valid_o ? ent_op[shift_idx]   : OP_ADD;
    shift_src1_o = shift_valid_o ? ent_src1[shift_idx] : '0;
    shift_src2_o = shift_valid_o ? ent_src2[shift_idx] : '0;
    shift_tag_o  = shift_valid_o ? rs_tag_t'(shift_idx) + rs_tag_t'(1) : '0;
    issue_vec    = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      issue_vec[i] = (alu_fire   && (alu_idx   == ADDR_W'(i))) ||
                     (shift_fire && (shift_idx == ADDR_W'(i)));
    end
  end

  // Lock the presented entry while the FU stalls the handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_lock_v     <= 1'b0;
      alu_lock_idx   <= '0;
      shift_lock_v   <= 1'b0;
      shift_lock_idx <= '0;
    end else begin
      alu_lock_v     <= alu_valid_o && !alu_ready_i;
      alu_lock_idx   <= alu_idx;
      shift_lock_v   <= shift_valid_o && !shift_ready_i;
      shift_lock_idx <= shift_idx;
    end
  end

  rs_station_bank_chk u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .busy_bus_i    (busy_bus_o)
  );

endmodule

// File: tb/tb_rs_station_bank.sv
// Scoreboard bench for rs_station_bank: directed allocations/CDB traffic push expected
// issue payloads; a negedge monitor pops and compares on every FU handshake.
module tb_rs_station_bank;
  import data_types::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              alloc_valid_i;
  logic [ADDR_W-1:0] alloc_addr_i;
  opcode_t           alloc_op_i;
  rs_tag_t           src1_tag_i, src2_tag_i;
  logic [XLEN-1:0]   src1_value_i, src2_value_i;
  logic              cdb_valid_i;
  rs_tag_t           cdb_tag_i;
  logic [XLEN-1:0]   cdb_value_i;
  logic [NUM_RS-1:0] busy_bus_o;
  logic              alu_valid_o, alu_ready_i, shift_valid_o, shift_ready_i;
  opcode_t           alu_op_o, shift_op_o;
  logic [XLEN-1:0]   alu_src1_o, alu_src2_o, shift_src1_o, shift_src2_o;
  rs_tag_t           alu_tag_o, shift_tag_o;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic [2:0]      tag;
  } exp_t;

  exp_t alu_q[$];
  exp_t shift_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_station_bank dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .alloc_op_i(alloc_op_i),
    .src1_tag_i(src1_tag_i), .src2_tag_i(src2_tag_i),
    .src1_value_i(src1_value_i), .src2_value_i(src2_value_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .busy_bus_o(busy_bus_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_op_o(alu_op_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_tag_o(alu_tag_o),
    .shift_valid_o(shift_valid_o), .shift_ready_i(shift_ready_i), .shift_op_o(shift_op_o),
    .shift_src1_o(shift_src1_o), .shift_src2_o(shift_src2_o), .shift_tag_o(shift_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_alloc(input logic [ADDR_W-1:0] a, input opcode_t op,
                           input rs_tag_t t1, input logic [XLEN-1:0] v1,
                           input rs_tag_t t2, input logic [XLEN-1:0] v2);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
    alloc_op_i    = op;
    src1_tag_i    = t1;
    src1_value_i  = v1;
    src2_tag_i    = t2;
    src2_value_i  = v2;
  endtask

  task automatic set_cdb(input rs_tag_t t, input logic [XLEN-1:0] v);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = t;
    cdb_value_i = v;
  endtask

  task automatic clr_in();
    alloc_valid_i = 1'b0;
    cdb_valid_i   = 1'b0;
  endtask

  task automatic push_alu(input opcode_t op, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2, input logic [2:0] tag);
    exp_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.tag = tag;
    alu_q.push_back(e);
  endtask

  task automatic push_shift(input opcode_t op, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2, input logic [2:0] tag);
    exp_t e;
    e.op = op; e.s1 = s1; e.s2 = s2; e.tag = tag;
    shift_q.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected issue of that group
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && alu_valid_o && alu_ready_i) begin
      if (alu_q.size() == 0) begin
        check("alu_unexpected_issue", 64'(alu_tag_o), 64'd0);
      end else begin
        e = alu_q.pop_front();
        check("alu_op",   64'(alu_op_o),   64'(e.op));
        check("alu_src1", 64'(alu_src1_o), 64'(e.s1));
        check("alu_src2", 64'(alu_src2_o), 64'(e.s2));
        check("alu_tag",  64'(alu_tag_o),  64'(e.tag));
      end
    end
    if (!rst_i && shift_valid_o && shift_ready_i) begin
      if (shift_q.size() == 0) begin
        check("shift_unexpected_issue", 64'(shift_tag_o), 64'd0);
      end else begin
        e = shift_q.pop_front();
        check("shift_op",   64'(shift_op_o),   64'(e.op));
        check("shift_src1", 64'(shift_src1_o), 64'(e.s1));
        check("shift_src2", 64'(shift_src2_o), 64'(e.s2));
        check("shift_tag",  64'(shift_tag_o),  64'(e.tag));
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    alloc_addr_i = '0; alloc_op_i = OP_ADD;
    src1_tag_i = '0; src2_tag_i = '0; src1_value_i = '0; src2_value_i = '0;
    cdb_tag_i = '0; cdb_value_i = '0;
    clr_in();
    alu_ready_i = 1'b1;
    shift_ready_i = 1'b1;

    @(negedge clk_i);
    check("reset_busy", 64'(busy_bus_o), 64'd0);
    check("reset_alu_valid", 64'(alu_valid_o), 64'd0);
    check("reset_shift_valid", 64'(shift_valid_o), 64'd0);
    check("reset_alu_tag", 64'(alu_tag_o), 64'd0);
    check("reset_alu_src1", 64'(alu_src1_o), 64'd0);
    cyc();
    rst_i = 1'b0;

    // Entry 0, both operands valid: issue the cycle after allocation
    set_alloc(3'd0, OP_ADD, 3'd0, 32'd5, 3'd0, 32'd7);
    push_alu(OP_ADD, 32'd5, 32'd7, 3'd1);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t1_busy", 64'(busy_bus_o), 64'b000001);
    check("t1_alu_valid", 64'(alu_valid_o), 64'd1);
    cyc();
    @(negedge clk_i);
    check("t1_issued_valid_low", 64'(alu_valid_o), 64'd0);
    check("t1_issued_busy", 64'(busy_bus_o), 64'b000001);

    // Entry 3 waits on tag 1; CDB tag 1 wakes it and also frees entry 0
    set_alloc(3'd3, OP_SLL, 3'd1, 32'd0, 3'd0, 32'd2);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t2_busy_wait", 64'(busy_bus_o), 64'b001001);
    check("t2_shift_not_ready", 64'(shift_valid_o), 64'd0);
    set_cdb(3'd1, 32'h000000AA);
    push_shift(OP_SLL, 32'h000000AA, 32'd2, 3'd4);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t2_shift_valid", 64'(shift_valid_o), 64'd1);
    check("t2_busy_after_free", 64'(busy_bus_o), 64'b001000);
    cyc();

    // Allocation bypass: src2 tag 3 resolved by same-cycle CDB
    set_alloc(3'd1, OP_SUB, 3'd0, 32'd20, 3'd3, 32'd0);
    set_cdb(3'd3, 32'd9);
    push_alu(OP_SUB, 32'd20, 32'd9, 3'd2);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t3_bypass_valid", 64'(alu_valid_o), 64'd1);
    check("t3_busy", 64'(busy_bus_o), 64'b001010);
    cyc();

    // Lock: entry 2 presented while stalled, entry 0 becomes READY later
    alu_ready_i = 1'b0;
    set_alloc(3'd2, OP_AND, 3'd0, 32'h11, 3'd0, 32'h22);
    push_alu(OP_AND, 32'h11, 32'h22, 3'd3);
    push_alu(OP_OR, 32'h33, 32'h44, 3'd1);
    cyc();
    set_alloc(3'd0, OP_OR, 3'd0, 32'h33, 3'd0, 32'h44);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t4_locked_tag", 64'(alu_tag_o), 64'd3);
    check("t4_locked_src1", 64'(alu_src1_o), 64'h11);
    check("t4_busy", 64'(busy_bus_o), 64'b001111);
    cyc();
    @(negedge clk_i);
    check("t4_still_locked_tag", 64'(alu_tag_o), 64'd3);
    cyc();
    alu_ready_i = 1'b1;
    cyc();
    cyc();
    cyc();

    // Free entry 0 with a same-cycle reallocation (dropped), then reallocate
    set_cdb(3'd1, 32'h55);
    set_alloc(3'd0, OP_ADD, 3'd0, 32'h99, 3'd0, 32'h98);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t5_freed_busy", 64'(busy_bus_o), 64'b001110);
    check("t5_dropped_alloc_valid", 64'(alu_valid_o), 64'd0);
    set_alloc(3'd0, OP_XOR, 3'd0, 32'd1, 3'd0, 32'd2);
    push_alu(OP_XOR, 32'd1, 32'd2, 3'd1);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t5_realloc_busy", 64'(busy_bus_o), 64'b001111);
    set_alloc(3'd7, OP_ADD, 3'd0, 32'd3, 3'd0, 32'd4);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t5_out_of_range_busy", 64'(busy_bus_o), 64'b001111);
    check("t5_out_of_range_valid", 64'(alu_valid_o), 64'd0);

    // Fill every entry, then asynchronous reset mid-cycle
    shift_ready_i = 1'b0;
    set_alloc(3'd5, OP_SRL, 3'd0, 32'h80, 3'd0, 32'd3);
    cyc();
    set_alloc(3'd4, OP_SRA, 3'd2, 32'd0, 3'd0, 32'd1);
    cyc(); clr_in();
    @(negedge clk_i);
    check("t6_full_busy", 64'(busy_bus_o), 64'b111111);
    check("t6_shift_valid", 64'(shift_valid_o), 64'd1);
    check("t6_shift_tag", 64'(shift_tag_o), 64'd6);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_async_busy", 64'(busy_bus_o), 64'd0);
    check("t6_async_alu_valid", 64'(alu_valid_o), 64'd0);
    check("t6_async_shift_valid", 64'(shift_valid_o), 64'd0);
    check("t6_async_shift_tag", 64'(shift_tag_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    shift_ready_i = 1'b1;
    @(negedge clk_i);
    check("t6_post_reset_busy", 64'(busy_bus_o), 64'd0);
    check("t6_post_reset_shift_valid", 64'(shift_valid_o), 64'd0);

    check("alu_queue_drained", 64'(alu_q.size()), 64'd0);
    check("shift_queue_drained", 64'(shift_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_station_bank.md
# rs_station_bank

Reservation-station storage for the out-of-order core, directly downstream of `rs_monitor`. It holds `NUM_RS` entries, accepts an allocation into the slot that `rs_monitor` picked, and captures operands from the common data bus (CDB). It issues ready entries to the ALU and SHIFT functional units over valid/ready handshakes and frees each entry when its own result is broadcast. Its `busy_bus_o` drives `busy_bus_i` of `rs_monitor`.

## Interface
Parameters:
- `NUM_RS`, package constant 6: total entries; `[2:0]` are ALU, `[5:3]` are SHIFT.
- `XLEN`, package constant 32: operand width.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `alloc_valid_i`  in  1  allocate this cycle.
- `alloc_addr_i`  in  `$clog2(NUM_RS)`  target entry, from `rs_tag_address_o`.
- `alloc_op_i`  in  `opcode_t`  operation.
- `src1_tag_i`, `src2_tag_i`  in  `rs_tag_t`  producer tag; 0 means the value is already valid.
- `src1_value_i`, `src2_value_i`  in  `XLEN`  operand value, used when the tag is 0.
- `cdb_valid_i`  in  1  CDB broadcast.
- `cdb_tag_i`  in  `rs_tag_t`  broadcasting entry tag.
- `cdb_value_i`  in  `XLEN`  result value.
- `busy_bus_o`  out  `NUM_RS`  entry occupied.
- `alu_valid_o` / `shift_valid_o`  out  1  issue request.
- `alu_ready_i` / `shift_ready_i`  in  1  FU accepts.
- `alu_op_o`, `alu_src1_o`, `alu_src2_o`, `alu_tag_o`  out  issue payload; the SHIFT group has the identical set `shift_*`.

## Operation
- Each entry runs this FSM: FREE → WAIT (an operand tag is pending) → READY (both operands valid) → ISSUED → FREE.
- Allocation is accepted only if the entry is FREE at the clock edge.
  - Allocating to a non-FREE entry is ignored and fires a simulation assertion.
  - An out-of-range `alloc_addr_i` is ignored in the same way.
- Tag encoding: `rs_tag_t` = entry index + 1; value 0 means "no producer". The entry's own tag is index+1.
- Operand capture: in WAIT, if `cdb_valid_i` is high and `cdb_tag_i` equals a pending source tag, latch `cdb_value_i` and clear that tag. Both sources can capture in the same cycle.
- Allocation bypass: if the allocating source tag matches a same-cycle CDB broadcast, capture `cdb_value_i` at allocation. The entry enters READY directly when both operands resolve.
- Issue selection per group: pick the lowest-index READY entry. The chosen index is locked in a register while `valid && !ready`, so the payload stays stable until the handshake.
- Issue handshake: when valid && ready, the entry moves to ISSUED.
- Free: an ISSUED entry goes to FREE when `cdb_valid_i` is high and `cdb_tag_i` equals its own tag.
- `busy_bus_o[i]` is high in every state except FREE.
- The CDB tag is never 0; `cdb_valid_i` with tag 0 is ignored.

## Timing
- Reset: all entries FREE; `busy_bus_o = 0`; both `*_valid_o = 0`; payload outputs 0; lock registers cleared.
- Reset asserted mid-operation drops all entries immediately, regardless of state.
- Allocation at edge N:
  - `busy_bus_o` is high from cycle N+1.
  - With both operands valid, `*_valid_o` is high in cycle N+1.
- CDB wake at edge N → READY and eligible for issue at N+1.
- Handshake at edge N → entry ISSUED at N+1; the next READY entry of that group is presented at N+1.
- Free at edge N → busy bit low at N+1. The entry can be allocated again from edge N+1, not at edge N.
- All issue outputs are combinational from the entry registers and the lock registers; no combinational path from `alloc_*` to `*_valid_o`.
- A CDB broadcast can wake several entries and free one entry in the same cycle.

## Structure
- The package `data_types` defines:
  - constants `NUM_RS`, `NUM_ALU_RS = 3`, `XLEN`;
  - types `functional_group_t`, `rs_tag_t`, `opcode_t`, and `rs_state_t` (FREE/WAIT/READY/ISSUED).
- Sub-module `rs_entry`: one entry's FSM, operand capture and CDB compare, instantiated `NUM_RS` times.
- The bank holds the two priority selectors, the lock registers and the output muxes.

## Test plan
- Reset, then allocate entry 0 (ALU) with both tags 0 and values 5, 7; `alu_ready_i` = 1 → `busy_bus_o = 6'b000001` and `alu_valid_o` high one cycle later with src 5/7 and tag 1. Next cycle the entry is ISSUED and `alu_valid_o` is low.
- Allocate entry 3 (SHIFT) with `src1_tag_i = 1` → the entry stays WAIT. CDB tag 1, value 0xAA → `shift_valid_o` rises the following cycle with `shift_src1_o = 0xAA`.
- Allocate entry 1 with `src2_tag_i = 3` in the same cycle as CDB tag 3, value 9 → entry READY next cycle with `src2 = 9` (bypass).
- Hold `alu_ready_i` low with entry 2 presented; then make entry 0 READY → the payload stays entry 2 until the handshake, then entry 0 issues.
- Issue entry 0, then CDB tag 1 → `busy_bus_o[0]` clears the next cycle. Reallocate the same cycle as the CDB → ignored and the assertion fires; reallocate one cycle later → accepted.
- Fill all 6 entries, then assert `rst_i` asynchronously mid-cycle → `busy_bus_o = 0` and both valids low immediately.
